// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int unsigned NUM_DIGITS    = 5;
  localparam int unsigned SCRATCH_W     = 4 * NUM_DIGITS;
  localparam logic [3:0]  ADJ_THRESHOLD = 4'd5;
  localparam logic [3:0]  ADJ_ADD       = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle of the converter; master drives requests, slave returns digits.
interface bin2bcd_seq_if #(
  parameter int WIDTH = 14
);
  logic             start;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic [3:0]       BCD_0;
  logic [3:0]       BCD_1;
  logic [3:0]       BCD_2;
  logic [3:0]       BCD_3;
  logic [3:0]       BCD_4;

  modport master (
    output start, bin,
    input  busy, done, BCD_0, BCD_1, BCD_2, BCD_3, BCD_4
  );

  modport slave (
    input  start, bin,
    output busy, done, BCD_0, BCD_1, BCD_2, BCD_3, BCD_4
  );
endinterface

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = (digit_i >= ADJ_THRESHOLD) ? digit_i + ADJ_ADD : digit_i;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, WIDTH+1 cycles per conversion.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  bin2bcd_seq_if.slave       conv
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t                 state_q;
  logic [WIDTH-1:0]       sr_q, sr_d;
  logic [SCRATCH_W-1:0]   scr_q, scr_d, adj_w, out_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, done_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scr_q[4*g +: 4]),
      .digit_o (adj_w[4*g +: 4])
    );
  end

  // {scratch, shift register} shifted left as one word after digit correction
  always_comb begin
    scr_d = {adj_w[SCRATCH_W-2:0], sr_q[WIDTH-1]};
    sr_d  = sr_q << 1;
    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      scr_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (conv.start) begin
            sr_q    <= conv.bin;
            scr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scr_q <= scr_d;
          sr_q  <= sr_d;
          cnt_q <= cnt_d;
          if (cnt_q == LAST_CNT) state_q <= S_DONE;
        end
        S_DONE: begin
          out_q   <= scr_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign conv.busy  = busy_q;
  assign conv.done  = done_q;
  assign conv.BCD_0 = out_q[3:0];
  assign conv.BCD_1 = out_q[7:4];
  assign conv.BCD_2 = out_q[11:8];
  assign conv.BCD_3 = out_q[15:12];
  assign conv.BCD_4 = out_q[19:16];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: expected digits queued at start, checked at done.
module tb_bin2bcd_seq;

  localparam int W = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [19:0] sb_q[$];

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(W)) bus ();

  bin2bcd_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .conv  (bus)
  );

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    x = v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [19:0] digits();
    return {bus.BCD_4, bus.BCD_3, bus.BCD_2, bus.BCD_1, bus.BCD_0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted request: start sampled at the next edge, expectation queued.
  task automatic kick(input int unsigned v);
    bus.bin   = W'(v);
    bus.start = 1'b1;
    sb_q.push_back(to_bcd(v));
    cyc();
    bus.start = 1'b0;
    bus.bin   = W'($urandom);
  endtask

  // Edges until done is seen; -1 when the bound expires.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      cyc();
      n++;
      if (bus.done === 1'b1) return;
    end
    n = -1;
  endtask

  task automatic test_reset();
    logic [19:0] exp;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.bin = '0;
    repeat (3) cyc();
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
    exp = '0;
    n_cmp++; if (digits() !== exp) begin n_err++; $display("FAIL reset_digits got %h want %h", digits(), exp); end
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    int n;
    logic [19:0] exp;
    kick(0);
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL zero_accept busy got %b want 1", bus.busy); end
    wait_done(n);
    n_cmp++; if (n !== 15) begin n_err++; $display("FAIL zero_latency got %0d want 15", n); end
    exp = sb_q.pop_front();
    n_cmp++; if (digits() !== exp) begin n_err++; $display("FAIL zero_digits got %h want %h", digits(), exp); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL zero_busy_after got %b want 0", bus.busy); end
  endtask

  task automatic test_max();
    int bc, dc;
    logic [19:0] exp;
    kick(16383);
    bc = (bus.busy === 1'b1) ? 1 : 0;
    dc = 0;
    repeat (20) begin
      cyc();
      if (bus.busy === 1'b1) bc++;
      if (bus.done === 1'b1) dc++;
    end
    n_cmp++; if (bc !== 15) begin n_err++; $display("FAIL max_busy_cycles got %0d want 15", bc); end
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL max_done_cycles got %0d want 1", dc); end
    exp = sb_q.pop_front();
    n_cmp++; if (digits() !== exp) begin n_err++; $display("FAIL max_digits got %h want %h", digits(), exp); end
  endtask

  task automatic test_ignore_busy();
    int n, dc;
    logic [19:0] exp;
    kick(9765);
    repeat (4) cyc();
    bus.bin   = W'(1234);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    wait_done(n);
    n_cmp++; if (n !== 10) begin n_err++; $display("FAIL ignore_latency got %0d want 10", n); end
    exp = sb_q.pop_front();
    n_cmp++; if (digits() !== exp) begin n_err++; $display("FAIL ignore_digits got %h want %h", digits(), exp); end
    dc = 0;
    repeat (25) begin
      cyc();
      if (bus.done === 1'b1) dc++;
    end
    n_cmp++; if (dc !== 0) begin n_err++; $display("FAIL ignore_second_done got %0d want 0", dc); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [19:0] exp;
    kick(1000);
    wait_done(n);
    n_cmp++; if (n !== 15) begin n_err++; $display("FAIL b2b_first_latency got %0d want 15", n); end
    exp = sb_q.pop_front();
    n_cmp++; if (digits() !== exp) begin n_err++; $display("FAIL b2b_first_digits got %h want %h", digits(), exp); end
    kick(42);
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept busy got %b want 1", bus.busy); end
    repeat (7) cyc();
    n_cmp++; if (digits() !== exp) begin n_err++; $display("FAIL b2b_hold got %h want %h", digits(), exp); end
    wait_done(n);
    n_cmp++; if (n !== 8) begin n_err++; $display("FAIL b2b_second_latency got %0d want 8", n); end
    exp = sb_q.pop_front();
    n_cmp++; if (digits() !== exp) begin n_err++; $display("FAIL b2b_second_digits got %h want %h", digits(), exp); end
  endtask

  task automatic test_reset_abort();
    int n, dc;
    logic [19:0] exp;
    kick(12345);
    repeat (7) cyc();
    rst_n = 1'b0;
    void'(sb_q.pop_front());
    #1;
    exp = '0;
    n_cmp++; if (digits() !== exp) begin n_err++; $display("FAIL abort_digits got %h want %h", digits(), exp); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    repeat (2) cyc();
    rst_n = 1'b1;
    dc = 0;
    repeat (20) begin
      cyc();
      if (bus.done === 1'b1) dc++;
    end
    n_cmp++; if (dc !== 0) begin n_err++; $display("FAIL abort_done got %0d want 0", dc); end
    kick(12345);
    wait_done(n);
    n_cmp++; if (n !== 15) begin n_err++; $display("FAIL abort_retry_latency got %0d want 15", n); end
    exp = sb_q.pop_front();
    n_cmp++; if (digits() !== exp) begin n_err++; $display("FAIL abort_retry_digits got %h want %h", digits(), exp); end
  endtask

  task automatic test_sweep();
    int unsigned corners[8] = '{0, 9, 10, 99, 100, 9999, 10000, 16383};
    int unsigned v;
    int n;
    logic [19:0] exp;
    for (int i = 0; i < 2000; i++) begin
      v = (i < 8) ? corners[i] : $urandom_range(0, 16383);
      kick(v);
      wait_done(n);
      n_cmp++; if (n !== 15) begin n_err++; $display("FAIL sweep_latency bin=%0d got %0d want 15", v, n); end
      exp = sb_q.pop_front();
      n_cmp++; if (digits() !== exp) begin n_err++; $display("FAIL sweep_digits bin=%0d got %h want %h", v, digits(), exp); end
    end
    n_cmp++; if (sb_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_left got %0d want 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter: WIDTH, default 14, binary input width; legal range 1..16.
REQ-002 Port: clk, input, 1, single system clock; all logic on rising edge.
REQ-003 Port: rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 Port: start, input, 1, conversion request; sampled on rising edge.
REQ-005 Port: bin, input, WIDTH, unsigned binary value to convert (frequency word bits [23:10] in the display path).
REQ-006 Port: busy, output, 1, high while a conversion is in progress.
REQ-007 Port: done, output, 1, one-cycle pulse when new digits are valid.
REQ-008 Ports: BCD_0..BCD_4, output, 4 each, registered decimal digits; BCD_0 = units, BCD_4 = ten-thousands.

Function
REQ-009 FSM shall have three states: IDLE, SHIFT, DONE.
REQ-010 IDLE: on edge with start=1, latch bin into the shift register, clear the 20-bit BCD scratch, load the iteration counter with 0, and go to SHIFT.
REQ-011 IDLE with start=0: hold the state; hold the outputs.
REQ-012 SHIFT, each edge: add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one bit, and increment the counter.
REQ-013 SHIFT: the edge performing shift number WIDTH shall move to DONE.
REQ-014 DONE, next edge: copy the scratch into BCD_0..BCD_4, set done=1 for exactly one cycle, and return to IDLE.
REQ-015 Latency: start is sampled at edge k; digits and done are updated at edge k+WIDTH+1 (edge k+15 for WIDTH=14).
REQ-016 busy = (state != IDLE): high from edge k to edge k+WIDTH+1.
REQ-017 start while busy=1 shall be ignored, with no queuing; bin changes during a conversion shall have no effect.
REQ-018 start in the cycle done is high is accepted: back-to-back throughput is one conversion per WIDTH+1 cycles.
REQ-019 BCD outputs shall hold the last result until the next DONE; they never show partial results.
REQ-020 Arithmetic: every digit is always in 0..9; bin = 0 yields all-zero digits; the maximum 2^WIDTH-1 converts exactly, with no overflow for WIDTH <= 16.

Reset
REQ-021 While rst_n=0: state=IDLE, busy=0, done=0, BCD_0..BCD_4=0, counter=0, scratch=0.
REQ-022 Reset asserted mid-conversion aborts the conversion; no done pulse is produced; outputs read 0.
REQ-023 After rst_n deasserts, the first start is accepted on the first rising edge.

Structure
REQ-024 Shared package: FSM state encodings, NUM_DIGITS=5, ADJ_THRESHOLD=5, ADJ_ADD=3.
REQ-025 One sub-module, bcd_digit_adj: combinational 4-bit "add 3 if >= 5"; instantiated five times.
REQ-026 Counter width: clog2(WIDTH+1) bits; no other arithmetic beyond the per-digit 4-bit add.

Verification
REQ-027 Reset, then start with bin=0 -> done at edge k+15; all digits 0; busy low afterwards.
REQ-028 bin=16383 -> BCD_4..BCD_0 = 1,6,3,8,3; done high for exactly one cycle; busy high for exactly 15 cycles.
REQ-029 bin=9765, then start re-pulsed at k+5 with bin=1234 -> the second start is ignored; result 0,9,7,6,5; no second done.
REQ-030 Start for 1000, then start for 42 in the done cycle -> outputs 0,1,0,0,0, then 0,0,0,4,2 fifteen cycles later.
REQ-031 rst_n pulsed low at k+7 of a 12345 conversion -> outputs 0 immediately; no done; next start for 12345 gives 1,2,3,4,5.
REQ-032 Random sweep of 2000 values including 0, 9, 10, 99, 100, 9999, 10000, 16383 -> decimal value of the digits equals bin in every case.
